// File: rtl/pc_redirect_arb_pkg.sv
// pcr_pkg: shared types and default widths for the PC redirect arbiter.
// Revision: 1.0
`default_nettype none

package pcr_pkg;

    localparam int PCR_NREQ = 3;
    localparam int PCR_PCW  = 32;
    localparam int PCR_IDXW = 3;
    localparam int PCR_SRCW = (PCR_NREQ > 1) ? $clog2(PCR_NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        ISSUE = 2'd2
    } pcr_state_e;

    // 'type' is a reserved word, so the type bit is carried as rtype.
    typedef struct packed {
        logic                rtype;
        logic [PCR_IDXW-1:0] idx;
        logic [PCR_PCW-1:0]  pc;
    } pcr_payload_t;

endpackage : pcr_pkg

`default_nettype wire

// File: rtl/pc_redirect_arb_prio_pick.sv
// pcr_prio_pick: combinational picker, first eligible source scanning upward
// from i_ptr (wrapping). A zero pointer gives plain fixed priority. Revision: 1.0
`default_nettype none

module pcr_prio_pick #(
    parameter int NREQ = 3,
    parameter int SRCW = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [NREQ-1:0] i_mask,
    input  logic [SRCW-1:0] i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [SRCW-1:0] o_idx,
    output logic            o_any
);

    logic [NREQ-1:0] w_elig;

    always_comb begin
        int j;
        j       = 0;
        w_elig  = i_req & i_mask;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(i_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!o_any && w_elig[j]) begin
                o_grant[j] = 1'b1;
                o_idx      = SRCW'(j);
                o_any      = 1'b1;
            end
        end
    end

endmodule : pcr_prio_pick

`default_nettype wire

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb: arbitrates PC corrections, flushes fetch, issues one redirect.
// Build macro PCR_RR_EN: round-robin IDLE grant, no FLUSH preemption. Revision: 1.0
`default_nettype none

module pc_redirect_arb
    import pcr_pkg::*;
#(
    parameter int NREQ         = PCR_NREQ,
    parameter int PCW          = PCR_PCW,
    parameter int IDXW         = PCR_IDXW,
    parameter int FLUSH_CYCLES = 2,
    localparam int SRCW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ-1:0]      i_req_type,
    input  logic [NREQ*IDXW-1:0] i_req_idx,
    input  logic [NREQ*PCW-1:0]  i_req_pc,
    output logic                 o_flush,
    output logic                 o_redir_valid,
    input  logic                 i_redir_ready,
    output logic                 o_redir_type,
    output logic [IDXW-1:0]      o_redir_idx,
    output logic [PCW-1:0]       o_redir_pc,
    output logic [SRCW-1:0]      o_redir_src,
    output logic                 o_busy
);

    localparam int            CNTW     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNTW-1:0] c_CNT_RELOAD = CNTW'(FLUSH_CYCLES - 1);

    pcr_state_e       r_state;
    logic [CNTW-1:0]  r_cnt;
    logic             r_flush;
    logic             r_valid;
    logic             r_busy;
    logic             r_type;
    logic [IDXW-1:0]  r_idx;
    logic [PCW-1:0]   r_pc;
    logic [SRCW-1:0]  r_src;

    logic [NREQ-1:0]  w_mask;
    logic [SRCW-1:0]  w_ptr;
    logic [NREQ-1:0]  w_grant;
    logic [SRCW-1:0]  w_gidx;
    logic             w_any;

`ifdef PCR_RR_EN
    logic [SRCW-1:0]  r_ptr;
    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    always_comb begin
        w_mask = '0;
        if (r_state == IDLE) begin
            w_mask = '1;
        end
`ifndef PCR_RR_EN
        else if (r_state == FLUSH) begin
            // Only strictly higher-priority sources may preempt a flush.
            for (int i = 0; i < NREQ; i++) begin
                w_mask[i] = (SRCW'(i) < r_src);
            end
        end
`endif
    end

    pcr_prio_pick #(
        .NREQ (NREQ),
        .SRCW (SRCW)
    ) u_pick (
        .i_req   (i_req_valid),
        .i_mask  (w_mask),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    assign o_req_ready = w_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_flush <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_type  <= 1'b0;
            r_idx   <= '0;
            r_pc    <= '0;
            r_src   <= '0;
`ifdef PCR_RR_EN
            r_ptr   <= '0;
`endif
        end else begin
            // Any grant (IDLE accept or FLUSH preemption) captures a fresh payload.
            if (w_any) begin
                r_type <= i_req_type[w_gidx];
                r_idx  <= i_req_idx[w_gidx*IDXW +: IDXW];
                r_pc   <= i_req_pc[w_gidx*PCW +: PCW];
                r_src  <= w_gidx;
                r_cnt  <= c_CNT_RELOAD;
            end
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= FLUSH;
                        r_flush <= 1'b1;
                        r_busy  <= 1'b1;
`ifdef PCR_RR_EN
                        r_ptr   <= (w_gidx == SRCW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
`endif
                    end
                end
                FLUSH: begin
                    if (!w_any) begin
                        if (r_cnt == '0) begin
                            r_state <= ISSUE;
                            r_flush <= 1'b0;
                            r_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (i_redir_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_flush <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_flush       = r_flush;
    assign o_redir_valid = r_valid;
    assign o_busy        = r_busy;
    assign o_redir_type  = r_type;
    assign o_redir_idx   = r_idx;
    assign o_redir_pc    = r_pc;
    assign o_redir_src   = r_src;

endmodule : pc_redirect_arb

`default_nettype wire

// File: doc/pc_redirect_arb.md
# pc_redirect_arb

Arbitrates PC-correction requests from several correction sources (non-branch-jump predecode correction, branch resolution, exception/replay) and sequences the single redirect into the fetch PC logic. For each accepted request it flushes the fetch queue for a fixed number of cycles, then presents the redirect (`type`, slot index, corrected PC) to the fetch stage with a valid/ready handshake. It sits between the correction producers and the fetch PC register, so exactly one redirect is in flight at a time.

## Interface
Parameters:
- `NREQ`, 3: number of correction sources. Index 0 has the highest fixed priority.
- `PCW`, 32: PC width.
- `IDXW`, 3: fetch-slot index width.
- `FLUSH_CYCLES`, 2: number of cycles `flush` is held per redirect. Must be ≥1.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-source request valid.
- `req_ready`  out  NREQ  per-source accept. At most one bit is set.
- `req_type`  in  NREQ  per-source redirect type bit.
- `req_idx`  in  NREQ*IDXW  per-source slot index, packed with source i at `[i*IDXW +: IDXW]`.
- `req_pc`  in  NREQ*PCW  per-source corrected PC, packed the same way.
- `flush`  out  1  fetch-queue flush, level.
- `redir_valid`  out  1  redirect valid.
- `redir_ready`  in  1  fetch stage accepts the redirect.
- `redir_type`  out  1  latched type.
- `redir_idx`  out  IDXW  latched slot index.
- `redir_pc`  out  PCW  latched PC.
- `redir_src`  out  $clog2(NREQ)  source index of the latched request.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, FLUSH, ISSUE.
- A request is accepted when `req_valid[i] & req_ready[i]` is sampled at a rising edge. The payload is captured into holding registers on that edge.
- **IDLE:**
  - `req_ready` is the one-hot grant from the picker. It is combinational from `req_valid` and the state.
  - On accept: go to FLUSH and load the flush counter with `FLUSH_CYCLES-1`.
- **FLUSH:**
  - `flush=1`. The counter decrements each cycle.
  - When the counter reaches 0, go to ISSUE.
  - Preemption (fixed-priority mode only): `req_ready` grants the highest-priority valid source with index < `redir_src`. On such an accept the payload is replaced, `redir_src` is updated, and the counter reloads to `FLUSH_CYCLES-1`, so the flush restarts.
  - A request from a source with index ≥ `redir_src` is not accepted in FLUSH. It stays pending.
- **ISSUE:**
  - `redir_valid=1`. Payload is stable and `req_ready=0`.
  - On `redir_ready`: go to IDLE.
  - No preemption in ISSUE.
- The requester whose request was overwritten by preemption is not re-served. Its correction is superseded by the older, higher-priority redirect.
- Reset (asynchronous, any state): state goes to IDLE. All outputs and holding registers go to 0. The RR pointer goes to 0. Any in-flight redirect is dropped with no partial handshake.

## Timing
- Accept at edge k gives `flush=1` in cycles k+1 .. k+FLUSH_CYCLES, and `redir_valid=1` from cycle k+FLUSH_CYCLES+1.
- Redirect handshake at edge m: `redir_valid=0` in cycle m+1. The earliest next accept is edge m+1.
- Sustained throughput is one redirect per FLUSH_CYCLES+2 cycles when `redir_ready` is held high.
- All outputs are registered except `req_ready`.
- `busy` equals `flush | redir_valid`.

## Configuration
- Macro: `PCR_RR_EN`.
- **Defined:**
  - IDLE arbitration is round-robin, starting from a pointer.
  - The pointer becomes grant+1, modulo NREQ, on each IDLE accept.
  - FLUSH preemption is disabled: `req_ready=0` outside IDLE.
- **Undefined:**
  - Fixed priority, with index 0 highest.
  - FLUSH preemption is enabled as described under Operation.

## Structure
- Package `pcr_pkg` holds:
  - the state enum `pcr_state_e` (IDLE/FLUSH/ISSUE);
  - the struct `pcr_payload_t` (`type`, `idx`, `pc`);
  - localparams for the index/PC widths and the source-id width.
- One sub-module, `pcr_prio_pick`. It is a combinational picker with inputs request vector, mask and RR pointer, and outputs a one-hot grant plus an encoded index. It is used for both the IDLE grant and the FLUSH preemption mask.

## Test plan
- **Single request.** Source 1 raises valid with pc=0x0000_1040, idx=5, type=1; `redir_ready=1`.
  - `flush` is high 2 cycles.
  - `redir_valid` is high one cycle with the same payload and `redir_src=1`.
  - `busy` falls afterwards.
- **Simultaneous requests** from sources 0, 1 and 2 (fixed priority).
  - Source 0 is served first, then 1, then 2.
  - Each redirect is 4 cycles apart with `redir_ready` tied high.
- **Preemption.** Source 2 is accepted; during flush cycle 1, source 0 raises pc=0x8000_0000.
  - The payload switches to source 0.
  - `flush` lasts 3 cycles in total.
  - Only one `redir_valid` occurs, with pc=0x8000_0000.
- **Backpressure.** Hold `redir_ready=0` for 5 cycles in ISSUE with source 0 valid.
  - The payload stays stable.
  - `req_ready` stays 0.
  - Release: handshake, then source 0 is accepted on the next edge.
- **Reset mid-operation.** Assert `rst=0` during FLUSH.
  - All outputs go to 0 immediately.
  - After release there is no `redir_valid` until a new request arrives.
- **`PCR_RR_EN` build** with all 3 sources continuously valid.
  - Grant order is 0, 1, 2, 0.
  - A lower-index request during FLUSH is not accepted.
